// File: rtl/sprite_finder.sv
// sprite_finder: per-pixel hit test of one sprite rectangle against the
// scan position, with a fixed 3-clk path through a synchronous sprite ROM
// to a registered colour/opaque pair for the video mixer.
`timescale 1ns/1ps
module sprite_finder #(
    parameter int                 SPRITE_W    = 16,
    parameter int                 SPRITE_H    = 16,
    parameter int                 ADDR_W      = 8,
    parameter int                 V_ACTIVE    = 480,
    parameter int                 COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 8'hE3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixel_clk,
    input  logic               v_sync,
    input  logic [9:0]         h_pos_in,
    input  logic               active_in,
    input  logic [9:0]         sprite_x,
    input  logic [9:0]         sprite_y,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_en,
    output logic [COLOR_W-1:0] pixel_color,
    output logic               pixel_opaque,
    output logic               frame_done
);

    localparam int SHIFT = $clog2(SPRITE_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_LINE,
        S_SCAN,
        S_FRAME_END
    } state_t;

    state_t             state;
    logic [9:0]         v_line;
    logic [9:0]         x_lat;
    logic [9:0]         y_lat;
    logic               active_d;
    logic               hit0;
    logic               hit1;
    logic               hit2;
    logic [ADDR_W-1:0]  addr0;

    logic [10:0]        h_ext;
    logic [10:0]        v_ext;
    logic [10:0]        x_ext;
    logic [10:0]        y_ext;
    logic [10:0]        dx;
    logic [10:0]        dy;
    logic               in_x;
    logic               in_y;
    logic               hit_comb;
    logic [ADDR_W-1:0]  addr_comb;
    logic               last_line;

    // Rectangle test and ROM address; 11-bit compares so x/y + size never wraps.
    always_comb begin
        h_ext     = {1'b0, h_pos_in};
        v_ext     = {1'b0, v_line};
        x_ext     = {1'b0, x_lat};
        y_ext     = {1'b0, y_lat};
        dx        = h_ext - x_ext;
        dy        = v_ext - y_ext;
        in_x      = (h_ext >= x_ext) && (h_ext < x_ext + 11'(SPRITE_W));
        in_y      = (v_ext >= y_ext) && (v_ext < y_ext + 11'(SPRITE_H));
        hit_comb  = (state == S_SCAN) && pixel_clk && active_in && in_x && in_y;
        addr_comb = ADDR_W'(dy << SHIFT) + ADDR_W'(dx);
        last_line = (v_ext + 11'd1) == 11'(V_ACTIVE);
    end

    // Frame/line tracking FSM; v_sync relatches the sprite and restarts the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            v_line     <= '0;
            x_lat      <= '0;
            y_lat      <= '0;
            active_d   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            active_d   <= active_in;
            frame_done <= 1'b0;
            if (v_sync) begin
                x_lat  <= sprite_x;
                y_lat  <= sprite_y;
                v_line <= '0;
                state  <= S_WAIT_LINE;
            end else begin
                case (state)
                    S_IDLE: state <= S_IDLE;
                    S_WAIT_LINE: begin
                        if (active_in) state <= S_SCAN;
                    end
                    S_SCAN: begin
                        if (active_d && !active_in) begin
                            v_line     <= v_line + 10'd1;
                            state      <= last_line ? S_FRAME_END : S_WAIT_LINE;
                            frame_done <= last_line;
                        end
                    end
                    S_FRAME_END: state <= S_IDLE;
                    default:     state <= S_IDLE;
                endcase
            end
        end
    end

    // Hit pipeline: sample, ROM request, ROM data, colour/opaque; v_sync flushes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit0         <= 1'b0;
            hit1         <= 1'b0;
            hit2         <= 1'b0;
            addr0        <= '0;
            rom_addr     <= '0;
            rom_en       <= 1'b0;
            pixel_color  <= '0;
            pixel_opaque <= 1'b0;
        end else if (v_sync) begin
            hit0         <= 1'b0;
            hit1         <= 1'b0;
            hit2         <= 1'b0;
            rom_en       <= 1'b0;
            pixel_color  <= '0;
            pixel_opaque <= 1'b0;
        end else begin
            hit0 <= hit_comb;
            if (hit_comb) addr0 <= addr_comb;
            hit1   <= hit0;
            rom_en <= hit0;
            if (hit0) rom_addr <= addr0;
            hit2         <= hit1;
            pixel_color  <= hit2 ? rom_data : '0;
            pixel_opaque <= hit2 && (rom_data != TRANSPARENT);
        end
    end

endmodule

// File: tb/tb_sprite_finder.sv
// Self-checking bench for sprite_finder: randomized pixel strobe spacing,
// event-level reference model of frames/lines/hits, synchronous ROM model.
`timescale 1ns/1ps
module tb_sprite_finder;

    localparam int         V_ACTIVE = 480;
    localparam int         SW       = 16;
    localparam int         SH       = 16;
    localparam logic [7:0] TRANSP   = 8'hE3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixel_clk = 1'b0;
    logic       v_sync = 1'b0;
    logic       active_in = 1'b0;
    logic [9:0] h_pos_in = '0;
    logic [9:0] sprite_x = '0;
    logic [9:0] sprite_y = '0;
    logic [7:0] rom_data = '0;
    logic [7:0] rom_addr;
    logic [7:0] pixel_color;
    logic       rom_en;
    logic       pixel_opaque;
    logic       frame_done;

    sprite_finder #(
        .SPRITE_W(SW),
        .SPRITE_H(SH),
        .ADDR_W(8),
        .V_ACTIVE(V_ACTIVE),
        .COLOR_W(8),
        .TRANSPARENT(TRANSP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pixel_clk(pixel_clk),
        .v_sync(v_sync),
        .h_pos_in(h_pos_in),
        .active_in(active_in),
        .sprite_x(sprite_x),
        .sprite_y(sprite_y),
        .rom_data(rom_data),
        .rom_addr(rom_addr),
        .rom_en(rom_en),
        .pixel_color(pixel_color),
        .pixel_opaque(pixel_opaque),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous sprite ROM: data one clk after the read strobe.
    logic [7:0] mem [256];
    always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

    int errors = 0;
    int checks = 0;
    int ecount = 0;
    int fd_seen = 0;

    // Reference model: frame enabled after v_sync, line = falling edges seen,
    // hits[edge] = ROM address of a pixel that lies inside the latched rectangle.
    bit m_en = 1'b0;
    bit m_prev_act = 1'b0;
    bit m_prev_vs = 1'b0;
    int m_line = 0;
    int m_x = 0;
    int m_y = 0;
    int last_flush = 0;
    int fd_edge = -1;
    int hits [int];

    task automatic model_edge(input int e, input bit pc, input bit vs, input int h, input bit act);
        if (!rst) begin
            m_en = 1'b0; m_prev_act = 1'b0; m_prev_vs = 1'b0; last_flush = e;
            return;
        end
        if (vs) begin
            m_x = int'(sprite_x); m_y = int'(sprite_y); m_line = 0; m_en = 1'b1; last_flush = e;
        end else if (m_en && m_prev_act && !m_prev_vs) begin
            if (act) begin
                if (pc && h >= m_x && h < m_x + SW && m_line >= m_y && m_line < m_y + SH)
                    hits[e] = ((m_line - m_y) * SW + (h - m_x)) % 256;
            end else begin
                m_line++;
                if (m_line == V_ACTIVE) begin
                    m_en = 1'b0;
                    fd_edge = e;
                end
            end
        end
        m_prev_act = act;
        m_prev_vs = vs;
    endtask

    task automatic check(input int e);
        bit         exp_en;
        bit         exp_op;
        logic [7:0] exp_col;
        exp_en = hits.exists(e - 1) && (last_flush <= e - 1);
        checks++;
        assert (rom_en === exp_en) else begin
            errors++;
            $error("FAIL rom_en edge=%0d got=%b exp=%b", e, rom_en, exp_en);
        end
        if (exp_en) begin
            checks++;
            assert (rom_addr === 8'(hits[e - 1])) else begin
                errors++;
                $error("FAIL rom_addr edge=%0d got=%0d exp=%0d", e, rom_addr, hits[e - 1]);
            end
        end
        exp_col = '0;
        exp_op = 1'b0;
        if (hits.exists(e - 3) && (last_flush <= e - 3)) begin
            exp_col = mem[hits[e - 3]];
            exp_op = (exp_col != TRANSP);
        end
        checks++;
        assert (pixel_opaque === exp_op) else begin
            errors++;
            $error("FAIL pixel_opaque edge=%0d got=%b exp=%b", e, pixel_opaque, exp_op);
        end
        checks++;
        assert (pixel_color === exp_col) else begin
            errors++;
            $error("FAIL pixel_color edge=%0d got=%h exp=%h", e, pixel_color, exp_col);
        end
        checks++;
        assert (frame_done === (fd_edge == e)) else begin
            errors++;
            $error("FAIL frame_done edge=%0d got=%b exp=%b", e, frame_done, (fd_edge == e));
        end
        if (frame_done === 1'b1) fd_seen++;
    endtask

    task automatic chk_zero(input string tag);
        checks++;
        assert ({rom_en, pixel_opaque, frame_done, rom_addr, pixel_color} === 19'd0) else begin
            errors++;
            $error("FAIL %s got=%b/%b/%b/%h/%h exp=all zero", tag,
                   rom_en, pixel_opaque, frame_done, rom_addr, pixel_color);
        end
    endtask

    // One clk: drive at the falling edge, model the next rising edge, check after it.
    task automatic step(input bit pc, input bit vs, input int h, input bit act);
        pixel_clk = pc;
        v_sync    = vs;
        h_pos_in  = 10'(h);
        active_in = act;
        ecount++;
        model_edge(ecount, pc, vs, h, act);
        @(negedge clk);
        check(ecount);
    endtask

    // One active line over columns h0..h1, 1..maxr clks per pixel, then a blank gap.
    task automatic line(input int h0, input int h1, input int maxr);
        int r;
        step(1'b0, 1'b0, h0, 1'b1);
        for (int h = h0; h <= h1; h++) begin
            r = $urandom_range(1, maxr);
            for (int k = 1; k <= r; k++) step(k == r, 1'b0, h, 1'b1);
        end
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic vsync(input int x, input int y);
        sprite_x = 10'(x);
        sprite_y = 10'(y);
        step(1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            if (mem[i] == TRANSP) mem[i] = 8'h1C;
        end
        mem[5]  = TRANSP;
        mem[37] = TRANSP;

        // Power-on reset
        #2 rst = 1'b0;
        #1 chk_zero("reset_state");
        @(negedge clk);
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        rst = 1'b1;

        // Nothing renders before the first v_sync
        sprite_x = 10'd0; sprite_y = 10'd0;
        line(0, 20, 1);
        line(0, 20, 2);

        // Basic hit at (100,2), mid-frame position change ignored until next frame
        vsync(100, 2);
        line(0, 639, 2);
        sprite_x = 10'd300;
        line(0, 639, 3);
        line(0, 639, 1);
        line(0, 639, 2);
        vsync(300, 0);
        line(0, 639, 2);
        line(0, 639, 3);

        // Asynchronous reset in the middle of a hit run
        vsync(0, 0);
        step(1'b0, 1'b0, 0, 1'b1);
        for (int h = 0; h < 9; h++) step(1'b1, 1'b0, h, 1'b1);
        rst = 1'b0;
        #1 chk_zero("reset_midline");
        @(negedge clk);
        ecount++;
        model_edge(ecount, 1'b0, 1'b0, 0, 1'b0);
        check(ecount);
        step(1'b0, 1'b0, 0, 1'b0);
        rst = 1'b1;
        line(0, 639, 1);

        // Right-edge clipping, random top line
        vsync(630, $urandom_range(0, 1));
        line(0, 639, 2);
        line(0, 639, 1);
        line(0, 639, 2);

        // Full frame of short lines, sprite clipped at the bottom
        fd_seen = 0;
        vsync(2, 470);
        for (int l = 0; l < V_ACTIVE; l++) line(0, 5, 2);
        line(0, 5, 1);
        line(0, 5, 1);
        checks++;
        assert (fd_seen == 1) else begin
            errors++;
            $error("FAIL frame_done_count got=%0d exp=1", fd_seen);
        end

        // v_sync coincident with falling active_in while hits are in flight
        fd_seen = 0;
        vsync(0, 0);
        step(1'b0, 1'b0, 0, 1'b1);
        for (int h = 0; h < 6; h++) step(1'b1, 1'b0, h, 1'b1);
        sprite_x = 10'd2;
        sprite_y = 10'd0;
        step(1'b0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b0);
        line(0, 8, 1);
        line(0, 8, 2);
        checks++;
        assert (fd_seen == 0) else begin
            errors++;
            $error("FAIL collision_frame_done got=%0d exp=0", fd_seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
